// File: rtl/muxn_arb_pkg.sv
// muxn_arb_pkg: shared constants and helpers for the muxn_arb arbiter family.
// Contents: arbitration mode encodings and the round-robin pointer advance rule.
// Imported by muxn_arb and rr_pick.
package muxn_arb_pkg;

  // Arbitration modes selectable through the MODE parameter.
  localparam int MODE_FIXED = 0;  // lowest requesting index wins
  localparam int MODE_RR    = 1;  // rotating start, pointer follows last grant
  localparam int MODE_SEL   = 2;  // external sel input picks the channel

  // Index that follows idx in a ring of n channels (n need not be a power of 2).
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotating-start priority search over N request lines.
// Ports: req[N] requests, start[SELW] first index to examine;
//        gnt_idx[SELW] chosen index, gnt_vld set when any req is high.
// Purely combinational; a start of zero degenerates to fixed priority.
module rr_pick
  import muxn_arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] start,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_vld
);

  always_comb begin
    int base;
    int idx;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    // An out-of-range start cannot come from the pointer, but fall back to 0.
    base    = (int'(start) < N) ? int'(start) : 0;
    // Walk from the farthest position toward start so the nearest requester
    // is the last one written and therefore wins.
    for (int k = N - 1; k >= 0; k--) begin
      idx = base + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (req[idx]) begin
        gnt_idx = SELW'(idx);
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/muxn_arb.sv
// muxn_arb: N-channel registered multiplexer with valid/ready on each input
// and on the output; picks a source by fixed priority, round-robin or sel.
// Ports: clk, rst_n (async active-low); in_data[N*WIDTH], in_valid[N],
//        in_ready[N]; sel[SELW] (MODE 2 only); out_data[WIDTH], out_valid,
//        out_ready, out_src[SELW] (channel that produced out_data).
module muxn_arb
  import muxn_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = 2,
  parameter int MODE  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    out_src
);

  logic [SELW-1:0]  rr_ptr;
  logic [SELW-1:0]  pick_start;
  logic [SELW-1:0]  pick_idx;
  logic             pick_vld;
  logic             sel_vld;
  logic [SELW-1:0]  grant;
  logic             grant_valid;
  logic             load;
  logic             xfer;
  logic [WIDTH-1:0] grant_data;

  // Fixed priority is the rotating search pinned to start 0.
  assign pick_start = (MODE == MODE_RR) ? rr_ptr : '0;

  rr_pick #(
    .N    (N),
    .SELW (SELW)
  ) u_pick (
    .req     (in_valid),
    .start   (pick_start),
    .gnt_idx (pick_idx),
    .gnt_vld (pick_vld)
  );

  // Explicit select: only indices below N can match, so sel >= N never grants.
  always_comb begin
    sel_vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      if ((sel == SELW'(i)) && in_valid[i]) begin
        sel_vld = 1'b1;
      end
    end
  end

  always_comb begin
    if (MODE == MODE_SEL) begin
      grant       = sel;
      grant_valid = sel_vld;
    end else begin
      grant       = pick_idx;
      grant_valid = pick_vld;
    end
  end

  // Output register can take a word when empty or being drained this cycle.
  assign load = ~out_valid | out_ready;
  assign xfer = load & grant_valid;

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SELW'(i)) begin
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // One-hot (or zero) accept; out_ready reaches in_ready combinationally.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = xfer & (grant == SELW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (load) begin
      if (grant_valid) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_src   <= grant;
      end else begin
        // Drained with nothing to replace it; data and source keep last word.
        out_valid <= 1'b0;
      end
    end
  end

  // Pointer moves just past the winner so it gets lowest priority next time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if ((MODE == MODE_RR) && xfer) begin
      rr_ptr <= SELW'(rr_next(int'(grant), N));
    end
  end

endmodule

// File: tb/tb_muxn_arb.sv
// tb_muxn_arb: drives four muxn_arb instances (RR N=4, fixed N=4, select
// N=4 SELW=3, RR N=3) with directed scenarios and random traffic, and
// compares them against a transaction-level reference model.
module tb_muxn_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [127:0] in_data_a  [4];
  logic [3:0]   in_valid_a [4];
  logic [3:0]   sel_a      [4];
  logic         out_ready_a[4];
  logic [3:0]   in_ready_a [4];
  logic [31:0]  out_data_a [4];
  logic         out_valid_a[4];
  logic [3:0]   out_src_a  [4];

  int checks   = 0;
  int failures = 0;

  // Per-instance configuration and model state.
  int          m_n   [4] = '{4, 4, 4, 3};
  int          m_mode[4] = '{1, 0, 2, 1};
  logic        mv[4];
  logic [31:0] md[4];
  int          ms[4];
  int          mp[4];

  for (genvar k = 0; k < 4; k++) begin : g_dut
    localparam int NK = (k == 3) ? 3 : 4;
    localparam int MK = (k == 1) ? 0 : ((k == 2) ? 2 : 1);
    localparam int SK = (k == 2) ? 3 : 2;
    logic [NK-1:0] rdy;
    logic [SK-1:0] src;
    muxn_arb #(.WIDTH(32), .N(NK), .SELW(SK), .MODE(MK)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data_a[k][NK*32-1:0]),
      .in_valid  (in_valid_a[k][NK-1:0]),
      .in_ready  (rdy),
      .sel       (sel_a[k][SK-1:0]),
      .out_data  (out_data_a[k]),
      .out_valid (out_valid_a[k]),
      .out_ready (out_ready_a[k]),
      .out_src   (src)
    );
    assign in_ready_a[k] = 4'(rdy);
    assign out_src_a[k]  = 4'(src);
  end

  // Reference grant: which channel the rules say wins now, or -1.
  function automatic int ref_grant(int k);
    int n;
    int st;
    int s;
    n = m_n[k];
    if (m_mode[k] == 2) begin
      s = int'(sel_a[k]);
      if (s < n && in_valid_a[k][s]) return s;
      return -1;
    end
    st = (m_mode[k] == 1) ? mp[k] : 0;
    for (int d = 0; d < n; d++) begin
      if (in_valid_a[k][(st + d) % n]) return (st + d) % n;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_ready(int k);
    int g;
    g = ref_grant(k);
    if (g >= 0 && (!mv[k] || out_ready_a[k])) return 4'(1 << g);
    return 4'b0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      mv[k] = 1'b0; md[k] = '0; ms[k] = 0; mp[k] = 0;
    end
  endtask

  // Advance one clock: compute the model's next state from current inputs,
  // wait for the edge, then commit. Inputs are driven 1ns after the edge.
  task automatic tick();
    logic        nv[4];
    logic [31:0] nd[4];
    int          ns[4];
    int          np[4];
    int          g;
    for (int k = 0; k < 4; k++) begin
      nv[k] = mv[k]; nd[k] = md[k]; ns[k] = ms[k]; np[k] = mp[k];
      g = ref_grant(k);
      if (!mv[k] || out_ready_a[k]) begin
        if (g >= 0) begin
          nv[k] = 1'b1;
          nd[k] = in_data_a[k][g*32 +: 32];
          ns[k] = g;
          if (m_mode[k] == 1) np[k] = (g + 1) % m_n[k];
        end else begin
          nv[k] = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    if (rst_n) begin
      for (int k = 0; k < 4; k++) begin
        mv[k] = nv[k]; md[k] = nd[k]; ms[k] = ns[k]; mp[k] = np[k];
      end
    end
  endtask

  task automatic idle_all();
    for (int k = 0; k < 4; k++) begin
      in_data_a[k] = '0; in_valid_a[k] = '0; sel_a[k] = '0; out_ready_a[k] = 1'b1;
    end
  endtask

  task automatic test_reset();
    #12;
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_valid_a[k] !== 1'b0) begin failures++; $display("FAIL reset_valid[%0d]: got %0b want 0", k, out_valid_a[k]); end
      checks++; if (out_data_a[k] !== 32'h0) begin failures++; $display("FAIL reset_data[%0d]: got %0h want 0", k, out_data_a[k]); end
      checks++; if (out_src_a[k] !== 4'h0) begin failures++; $display("FAIL reset_src[%0d]: got %0d want 0", k, out_src_a[k]); end
      checks++; if (in_ready_a[k] !== 4'h0) begin failures++; $display("FAIL reset_ready[%0d]: got %b want 0000", k, in_ready_a[k]); end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_rr_sequence();
    int seq[5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 4; i++) in_data_a[0][i*32 +: 32] = 32'hA0 + i;
    in_valid_a[0] = 4'b1111; out_ready_a[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #3;
      checks++; if (in_ready_a[0] !== 4'(1 << seq[c])) begin failures++; $display("FAIL rr_ready c%0d: got %b want %b", c, in_ready_a[0], 4'(1 << seq[c])); end
      tick();
      checks++; if (out_valid_a[0] !== 1'b1) begin failures++; $display("FAIL rr_valid c%0d: got %0b want 1", c, out_valid_a[0]); end
      checks++; if (out_src_a[0] !== 4'(seq[c])) begin failures++; $display("FAIL rr_src c%0d: got %0d want %0d", c, out_src_a[0], seq[c]); end
      checks++; if (out_data_a[0] !== 32'hA0 + 32'(seq[c])) begin failures++; $display("FAIL rr_data c%0d: got %0h want %0h", c, out_data_a[0], 32'hA0 + 32'(seq[c])); end
    end
    in_valid_a[0] = 4'b0000;
    tick();
  endtask

  task automatic test_fixed_priority();
    for (int i = 0; i < 4; i++) in_data_a[1][i*32 +: 32] = 32'hB0 + i;
    in_valid_a[1] = 4'b0110; out_ready_a[1] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #3;
      checks++; if (in_ready_a[1] !== 4'b0010) begin failures++; $display("FAIL fix_ready c%0d: got %b want 0010", c, in_ready_a[1]); end
      tick();
      checks++; if (out_src_a[1] !== 4'd1) begin failures++; $display("FAIL fix_src c%0d: got %0d want 1", c, out_src_a[1]); end
      checks++; if (out_data_a[1] !== 32'hB1) begin failures++; $display("FAIL fix_data c%0d: got %0h want b1", c, out_data_a[1]); end
    end
    in_valid_a[1] = 4'b0000;
    tick();
  endtask

  task automatic test_stall();
    in_data_a[0][2*32 +: 32] = 32'h1234;
    in_valid_a[0] = 4'b0100; out_ready_a[0] = 1'b1;
    #3;
    checks++; if (in_ready_a[0] !== 4'b0100) begin failures++; $display("FAIL stall_first_ready: got %b want 0100", in_ready_a[0]); end
    tick();
    out_ready_a[0] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid_a[0] = 4'($urandom_range(0, 15));
      #3;
      checks++; if (in_ready_a[0] !== 4'b0000) begin failures++; $display("FAIL stall_ready c%0d: got %b want 0000", c, in_ready_a[0]); end
      checks++; if (out_valid_a[0] !== 1'b1) begin failures++; $display("FAIL stall_valid c%0d: got %0b want 1", c, out_valid_a[0]); end
      checks++; if (out_data_a[0] !== 32'h1234) begin failures++; $display("FAIL stall_data c%0d: got %0h want 1234", c, out_data_a[0]); end
      checks++; if (out_src_a[0] !== 4'd2) begin failures++; $display("FAIL stall_src c%0d: got %0d want 2", c, out_src_a[0]); end
      tick();
    end
    in_valid_a[0] = 4'b1111; out_ready_a[0] = 1'b1;
    #3;
    checks++; if (in_ready_a[0] !== 4'b1000) begin failures++; $display("FAIL stall_release_ready: got %b want 1000", in_ready_a[0]); end
    tick();
    checks++; if (out_src_a[0] !== 4'd3) begin failures++; $display("FAIL stall_release_src: got %0d want 3", out_src_a[0]); end
    checks++; if (out_data_a[0] !== 32'hA3) begin failures++; $display("FAIL stall_release_data: got %0h want a3", out_data_a[0]); end
    in_valid_a[0] = 4'b0000;
    tick();
  endtask

  task automatic test_select();
    for (int i = 0; i < 4; i++) in_data_a[2][i*32 +: 32] = 32'hC0 + i;
    sel_a[2] = 4'd3; in_valid_a[2] = 4'b1000; out_ready_a[2] = 1'b1;
    #3;
    checks++; if (in_ready_a[2] !== 4'b1000) begin failures++; $display("FAIL sel3_ready: got %b want 1000", in_ready_a[2]); end
    tick();
    checks++; if (out_valid_a[2] !== 1'b1 || out_src_a[2] !== 4'd3 || out_data_a[2] !== 32'hC3) begin
      failures++; $display("FAIL sel3_out: got v=%0b src=%0d data=%0h want v=1 src=3 data=c3", out_valid_a[2], out_src_a[2], out_data_a[2]); end
    in_valid_a[2] = 4'b0000;
    #3;
    checks++; if (in_ready_a[2] !== 4'b0000) begin failures++; $display("FAIL sel3_idle_ready: got %b want 0000", in_ready_a[2]); end
    tick();
    checks++; if (out_valid_a[2] !== 1'b0 || out_src_a[2] !== 4'd3 || out_data_a[2] !== 32'hC3) begin
      failures++; $display("FAIL sel3_drain: got v=%0b src=%0d data=%0h want v=0 src=3 data=c3", out_valid_a[2], out_src_a[2], out_data_a[2]); end
    sel_a[2] = 4'd5; in_valid_a[2] = 4'b1111;
    #3;
    checks++; if (in_ready_a[2] !== 4'b0000) begin failures++; $display("FAIL sel5_ready: got %b want 0000", in_ready_a[2]); end
    tick();
    checks++; if (out_valid_a[2] !== 1'b0) begin failures++; $display("FAIL sel5_valid: got %0b want 0", out_valid_a[2]); end
    sel_a[2] = 4'd1;
    #3;
    checks++; if (in_ready_a[2] !== 4'b0010) begin failures++; $display("FAIL sel1_ready: got %b want 0010", in_ready_a[2]); end
    tick();
    checks++; if (out_src_a[2] !== 4'd1 || out_data_a[2] !== 32'hC1) begin
      failures++; $display("FAIL sel1_out: got src=%0d data=%0h want src=1 data=c1", out_src_a[2], out_data_a[2]); end
    in_valid_a[2] = 4'b0000; sel_a[2] = 4'd0;
    tick();
  endtask

  task automatic test_wrap_n3();
    int seq[4] = '{0, 1, 2, 0};
    for (int i = 0; i < 4; i++) in_data_a[3][i*32 +: 32] = 32'hD0 + i;
    in_valid_a[3] = 4'b1111; out_ready_a[3] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #3;
      checks++; if (in_ready_a[3] !== 4'(1 << seq[c])) begin failures++; $display("FAIL n3_ready c%0d: got %b want %b", c, in_ready_a[3], 4'(1 << seq[c])); end
      tick();
      checks++; if (out_src_a[3] !== 4'(seq[c])) begin failures++; $display("FAIL n3_src c%0d: got %0d want %0d", c, out_src_a[3], seq[c]); end
      checks++; if (out_data_a[3] !== 32'hD0 + 32'(seq[c])) begin failures++; $display("FAIL n3_data c%0d: got %0h want %0h", c, out_data_a[3], 32'hD0 + 32'(seq[c])); end
    end
    in_valid_a[3] = 4'b0000;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 4; k++) begin
        for (int i = 0; i < 4; i++) in_data_a[k][i*32 +: 32] = $urandom;
        in_valid_a[k]  = 4'($urandom_range(0, 15));
        sel_a[k]       = (k == 2) ? 4'($urandom_range(0, 7)) : 4'd0;
        out_ready_a[k] = ($urandom_range(0, 3) != 0);
      end
      #3;
      for (int k = 0; k < 4; k++) begin
        checks++; if (in_ready_a[k] !== model_ready(k)) begin failures++; $display("FAIL rnd_ready[%0d] c%0d: got %b want %b", k, c, in_ready_a[k], model_ready(k)); end
        checks++; if (out_valid_a[k] !== mv[k]) begin failures++; $display("FAIL rnd_valid[%0d] c%0d: got %0b want %0b", k, c, out_valid_a[k], mv[k]); end
        checks++; if (out_data_a[k] !== md[k]) begin failures++; $display("FAIL rnd_data[%0d] c%0d: got %0h want %0h", k, c, out_data_a[k], md[k]); end
        checks++; if (out_src_a[k] !== 4'(ms[k])) begin failures++; $display("FAIL rnd_src[%0d] c%0d: got %0d want %0d", k, c, out_src_a[k], ms[k]); end
      end
      tick();
    end
    idle_all();
    tick();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) in_data_a[0][i*32 +: 32] = 32'hE0 + i;
    in_valid_a[0] = 4'b1111; out_ready_a[0] = 1'b1;
    #3;
    tick();
    out_ready_a[0] = 1'b0;
    #3;
    checks++; if (out_valid_a[0] !== 1'b1) begin failures++; $display("FAIL arst_pre_valid: got %0b want 1", out_valid_a[0]); end
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (out_valid_a[0] !== 1'b0) begin failures++; $display("FAIL arst_valid: got %0b want 0", out_valid_a[0]); end
    checks++; if (out_data_a[0] !== 32'h0) begin failures++; $display("FAIL arst_data: got %0h want 0", out_data_a[0]); end
    checks++; if (out_src_a[0] !== 4'h0) begin failures++; $display("FAIL arst_src: got %0d want 0", out_src_a[0]); end
    @(posedge clk); #1;
    out_ready_a[0] = 1'b1;
    rst_n = 1'b1;
    #3;
    checks++; if (in_ready_a[0] !== 4'b0001) begin failures++; $display("FAIL arst_first_ready: got %b want 0001", in_ready_a[0]); end
    tick();
    checks++; if (out_src_a[0] !== 4'd0 || out_data_a[0] !== 32'hE0) begin
      failures++; $display("FAIL arst_first_out: got src=%0d data=%0h want src=0 data=e0", out_src_a[0], out_data_a[0]); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    idle_all();
    model_reset();
    test_reset();
    test_rr_sequence();
    test_fixed_priority();
    test_stall();
    test_select();
    test_wrap_n3();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
